// File: rtl/freq_meter_pkg.sv
// Shared types and defaults for the frequency-meter gate controller.
package freq_meter_pkg;

  localparam int unsigned CNT_W_DEF       = 16;
  localparam int unsigned TMR_W_DEF       = 32;
  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = {CNT_W_DEF{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    CAPTURE = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/freq_gate_ctrl_if.sv
// Result bus. Transfer happens on a clk edge where result_valid & result_ready;
// the master holds result/overflow stable and keeps valid high until that edge.
interface freq_gate_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [CNT_W-1:0] result;
  logic             overflow;
  logic             result_valid;
  logic             result_ready;

  modport master (output result, output overflow, output result_valid, input result_ready);
  modport slave  (input result, input overflow, input result_valid, output result_ready);
endinterface

// File: rtl/freq_gate_ctrl_timer.sv
// Loadable down-counter defining the gate window; last marks the final gate cycle.
module gate_timer #(
  parameter int unsigned TMR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [TMR_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign last = (cnt_q == TMR_W'(1));

endmodule

// File: rtl/freq_gate_ctrl.sv
// Gate controller: opens the counter enable for N clk cycles, captures the count
// with saturation/overflow, and hands the result downstream over valid/ready.
module freq_gate_ctrl
  import freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned TMR_W       = TMR_W_DEF,
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  input  logic [TMR_W-1:0] gate_len,
  output logic             en_count,
  input  logic [CNT_W-1:0] count_in,
  output logic             busy,
  output state_t           state,
  freq_gate_ctrl_if.master res_bus
);

  localparam logic [CNT_W-1:0] CNT_ALL = '1;

  state_t           state_q, state_d;
  logic             en_q, busy_q, valid_q, ovf_q, trk_q, cont_q;
  logic [CNT_W-1:0] result_q;
  logic [TMR_W-1:0] len_q, n_sel, tmr_val;
  logic             tmr_load, tmr_en, tmr_last;
  logic             start_acc, capture, xfer, cnt_full;

  assign n_sel    = (gate_len == '0) ? TMR_W'(GATE_CYCLES) : gate_len;
  assign cnt_full = (count_in == CNT_ALL);
  assign xfer     = valid_q && res_bus.result_ready;

  gate_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .last     (tmr_last)
  );

  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_val   = len_q;
    tmr_en    = 1'b0;
    start_acc = 1'b0;
    capture   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = n_sel;
          state_d   = GATE;
        end
      end
      GATE: begin
        tmr_en = 1'b1;
        if (tmr_last) state_d = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = PRESENT;
      end
      PRESENT: begin
        // stop in the handshake cycle already wins over the continuous latch
        if (xfer) begin
          if (cont_q && !stop) begin
            tmr_load = 1'b1;
            state_d  = GATE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      trk_q    <= 1'b0;
      cont_q   <= 1'b0;
      result_q <= '0;
      len_q    <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= (state_d == GATE);
      busy_q  <= (state_d != IDLE);

      if (tmr_load) begin
        trk_q <= 1'b0;
      end else if ((state_q == GATE) && cnt_full) begin
        trk_q <= 1'b1;
      end

      if (start_acc) begin
        cont_q <= continuous && !stop;
        len_q  <= n_sel;
      end else if (stop) begin
        cont_q <= 1'b0;
      end

      if (capture) begin
        result_q <= (trk_q || cnt_full) ? CNT_ALL : count_in;
        ovf_q    <= trk_q || cnt_full;
        valid_q  <= 1'b1;
      end else if (xfer) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign en_count             = en_q;
  assign busy                 = busy_q;
  assign state                = state_q;
  assign res_bus.result       = result_q;
  assign res_bus.overflow     = ovf_q;
  assign res_bus.result_valid = valid_q;

endmodule
